// File: rtl/uart_frame_decoder_if.sv
// Byte-stream input, held-frame read port and error pulses of the UART frame decoder.
// The decoder connects through the slave modport and its environment through the master modport.
interface uart_frame_decoder_if #(
  parameter int MAX_LEN = 16
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [7:0]    rx_byte;
  logic          rx_complete;
  logic          frame_valid;
  logic [7:0]    frame_cmd;
  logic [LW-1:0] frame_len;
  logic          frame_ack;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          err_chk;
  logic          err_len;
  logic          err_timeout;
  logic          err_overrun;

  modport slave (
    input  rx_byte, rx_complete, frame_ack, rd_addr,
    output frame_valid, frame_cmd, frame_len, rd_data,
           err_chk, err_len, err_timeout, err_overrun
  );

  modport master (
    output rx_byte, rx_complete, frame_ack, rd_addr,
    input  frame_valid, frame_cmd, frame_len, rd_data,
           err_chk, err_len, err_timeout, err_overrun
  );
endinterface

// File: rtl/uart_frame_decoder.sv
// Parses SOF, CMD, LEN, payload[LEN], CHK packets from the UART byte stream and holds
// each checksum-good frame in a payload buffer until the consumer acknowledges it.
module uart_frame_decoder #(
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input logic                sourceClk,
  input logic                reset,
  uart_frame_decoder_if.slave bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_HUNT, ST_CMD, ST_LEN, ST_PAYLOAD, ST_CHK, ST_HOLD
  } state_t;

  state_t        state;
  logic [7:0]    cmd_r;
  logic [LW-1:0] len_r;
  logic [7:0]    sum;
  logic [AW-1:0] idx;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    buffer [MAX_LEN];

  wire sof_seen = bus.rx_complete && (bus.rx_byte == SOF_BYTE);

  // NOTE: all state here is sequential, so every assignment is non-blocking; a blocking
  // assignment would let later statements see the new value and race other always_ff blocks.
  always_ff @(posedge sourceClk) begin
    if (!reset) begin
      state           <= ST_HUNT;
      cmd_r           <= '0;
      len_r           <= '0;
      sum             <= '0;
      idx             <= '0;
      tmo_cnt         <= '0;
      bus.frame_valid <= 1'b0;
      bus.frame_cmd   <= '0;
      bus.frame_len   <= '0;
      bus.err_chk     <= 1'b0;
      bus.err_len     <= 1'b0;
      bus.err_timeout <= 1'b0;
      bus.err_overrun <= 1'b0;
    end else begin
      // Error flags are single-cycle pulses; the branches below raise them as needed.
      bus.err_chk     <= 1'b0;
      bus.err_len     <= 1'b0;
      bus.err_timeout <= 1'b0;
      bus.err_overrun <= 1'b0;

      case (state)
        ST_HUNT: begin
          if (sof_seen) begin
            state   <= ST_CMD;
            sum     <= '0;
            tmo_cnt <= '0;
          end
        end

        ST_HOLD: begin
          // An ack releases the frame and the same-cycle byte is judged as if in HUNT.
          if (bus.frame_ack) begin
            bus.frame_valid <= 1'b0;
            if (sof_seen) begin
              state   <= ST_CMD;
              sum     <= '0;
              tmo_cnt <= '0;
            end else begin
              state <= ST_HUNT;
            end
          end else if (bus.rx_complete) begin
            bus.err_overrun <= 1'b1;
          end
        end

        default: begin
          if (bus.rx_complete) begin
            tmo_cnt <= '0;
            case (state)
              ST_CMD: begin
                cmd_r <= bus.rx_byte;
                sum   <= bus.rx_byte;
                state <= ST_LEN;
              end
              ST_LEN: begin
                if (bus.rx_byte > MAX_LEN_B) begin
                  bus.err_len <= 1'b1;
                  state       <= ST_HUNT;
                end else begin
                  len_r <= bus.rx_byte[LW-1:0];
                  sum   <= sum + bus.rx_byte;
                  idx   <= '0;
                  state <= (bus.rx_byte == 8'd0) ? ST_CHK : ST_PAYLOAD;
                end
              end
              ST_PAYLOAD: begin
                sum <= sum + bus.rx_byte;
                idx <= idx + AW'(1);
                if (LW'(idx) == len_r - LW'(1)) state <= ST_CHK;
              end
              default: begin
                if (8'(sum + bus.rx_byte) == 8'd0) begin
                  bus.frame_cmd   <= cmd_r;
                  bus.frame_len   <= len_r;
                  bus.frame_valid <= 1'b1;
                  state           <= ST_HOLD;
                end else begin
                  bus.err_chk <= 1'b1;
                  state       <= ST_HUNT;
                end
              end
            endcase
          end else if (tmo_cnt == TMO_LAST) begin
            bus.err_timeout <= 1'b1;
            state           <= ST_HUNT;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
      endcase
    end
  end

  // NOTE: the payload array deliberately has no reset so it maps onto plain RAM; its
  // contents are only meaningful while frame_valid is high.
  always_ff @(posedge sourceClk) begin
    if (reset && state == ST_PAYLOAD && bus.rx_complete) buffer[idx] <= bus.rx_byte;
  end

  always_ff @(posedge sourceClk) begin
    if (!reset) bus.rd_data <= '0;
    else        bus.rd_data <= buffer[bus.rd_addr];
  end
endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder: good/bad frames, length limits, noise,
// inter-byte timeout, overrun, ack/SOF collision and reset in the middle of a frame.
module tb_uart_frame_decoder;
  localparam int MAX_LEN = 16;
  localparam int TMO     = 64;

  logic sourceClk = 1'b0;
  logic reset     = 1'b0;
  always #5 sourceClk = ~sourceClk;

  uart_frame_decoder_if #(.MAX_LEN(MAX_LEN)) bus ();

  uart_frame_decoder #(
    .SOF_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .sourceClk(sourceClk),
    .reset    (reset),
    .bus      (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_chk = 0, n_len = 0, n_tmo = 0, n_ovr = 0;
  logic [7:0] q [$];

  // Error pulses are tallied between edges so single-cycle pulses are never missed.
  always @(negedge sourceClk) begin
    if (bus.err_chk)     n_chk++;
    if (bus.err_len)     n_len++;
    if (bus.err_timeout) n_tmo++;
    if (bus.err_overrun) n_ovr++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge sourceClk);
  endtask

  // Sends q back-to-back on consecutive cycles, then idles rx_complete.
  task automatic send_q();
    foreach (q[i]) begin
      @(negedge sourceClk);
      bus.rx_byte     = q[i];
      bus.rx_complete = 1'b1;
    end
    @(negedge sourceClk);
    bus.rx_complete = 1'b0;
  endtask

  task automatic read_byte(input int addr, input logic [7:0] exp, input string tag);
    bus.rd_addr = 4'(addr);
    @(negedge sourceClk);
    check(tag, 32'(bus.rd_data), 32'(exp));
  endtask

  task automatic ack();
    @(negedge sourceClk);
    bus.frame_ack = 1'b1;
    @(negedge sourceClk);
    bus.frame_ack = 1'b0;
  endtask

  initial begin
    bus.rx_byte     = '0;
    bus.rx_complete = 1'b0;
    bus.frame_ack   = 1'b0;
    bus.rd_addr     = '0;
    cycles(3);
    check("rst_valid",   32'(bus.frame_valid), 0);
    check("rst_cmd",     32'(bus.frame_cmd),   0);
    check("rst_len",     32'(bus.frame_len),   0);
    check("rst_rd_data", 32'(bus.rd_data),     0);
    check("rst_errs", 32'({bus.err_chk, bus.err_len, bus.err_timeout, bus.err_overrun}), 0);
    reset = 1'b1;

    // Noise before any SOF is dropped silently.
    q = {8'h00, 8'hFF, 8'h5A};
    send_q();
    cycles(2);
    check("noise_errs",  32'(n_chk + n_len + n_tmo + n_ovr), 0);
    check("noise_valid", 32'(bus.frame_valid), 0);

    // Good frame, then readback and overrun while held.
    q = {8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
    send_q();
    check("good_valid", 32'(bus.frame_valid), 1);
    check("good_cmd",   32'(bus.frame_cmd),   32'h10);
    check("good_len",   32'(bus.frame_len),   3);
    read_byte(2, 8'h33, "good_rd2");
    read_byte(0, 8'h11, "good_rd0");
    q = {8'h42};
    send_q();
    cycles(1);
    check("ovr_pulse", 32'(n_ovr), 1);
    check("ovr_valid", 32'(bus.frame_valid), 1);
    check("ovr_cmd",   32'(bus.frame_cmd),   32'h10);
    check("ovr_len",   32'(bus.frame_len),   3);
    read_byte(1, 8'h22, "ovr_rd1");
    ack();
    check("ack_drop", 32'(bus.frame_valid), 0);

    // Bad checksum is rejected; the next good frame is taken.
    q = {8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h88};
    send_q();
    cycles(1);
    check("bad_chk_pulse", 32'(n_chk), 1);
    check("bad_chk_valid", 32'(bus.frame_valid), 0);
    q = {8'hA5, 8'h20, 8'h02, 8'h01, 8'h02, 8'hDB};
    send_q();
    check("after_bad_valid", 32'(bus.frame_valid), 1);
    check("after_bad_cmd",   32'(bus.frame_cmd),   32'h20);
    read_byte(1, 8'h02, "after_bad_rd1");

    // Ack and SOF in the same cycle: new zero-length frame, no overrun.
    @(negedge sourceClk);
    bus.frame_ack   = 1'b1;
    bus.rx_byte     = 8'hA5;
    bus.rx_complete = 1'b1;
    @(negedge sourceClk);
    bus.frame_ack = 1'b0;
    check("coll_drop", 32'(bus.frame_valid), 0);
    bus.rx_byte = 8'h01;
    @(negedge sourceClk);
    bus.rx_byte = 8'h00;
    @(negedge sourceClk);
    bus.rx_byte = 8'hFF;
    @(negedge sourceClk);
    bus.rx_complete = 1'b0;
    check("zero_valid", 32'(bus.frame_valid), 1);
    check("zero_cmd",   32'(bus.frame_cmd),   32'h01);
    check("zero_len",   32'(bus.frame_len),   0);
    check("coll_no_ovr", 32'(n_ovr), 1);
    ack();

    // LEN above MAX_LEN, then an immediate good frame proves return to HUNT.
    q = {8'hA5, 8'h01, 8'h11};
    send_q();
    cycles(1);
    check("len_pulse", 32'(n_len), 1);
    q = {8'hA5, 8'h30, 8'h01, 8'h7E, 8'h51};
    send_q();
    check("after_len_valid", 32'(bus.frame_valid), 1);
    check("after_len_cmd",   32'(bus.frame_cmd),   32'h30);
    ack();

    // LEN == MAX_LEN is accepted; payload 00..0F.
    q = {8'hA5, 8'h40, 8'h10};
    for (int i = 0; i < 16; i++) q.push_back(8'(i));
    q.push_back(8'h38);
    send_q();
    check("max_valid", 32'(bus.frame_valid), 1);
    check("max_len",   32'(bus.frame_len),   16);
    read_byte(15, 8'h0F, "max_rd15");
    read_byte(7,  8'h07, "max_rd7");
    ack();

    // Stall after CMD: exactly one timeout pulse, not early.
    q = {8'hA5, 8'h10};
    send_q();
    cycles(TMO - 2);
    check("tmo_not_early", 32'(n_tmo), 0);
    cycles(20);
    check("tmo_pulse", 32'(n_tmo), 1);
    q = {8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
    send_q();
    check("after_tmo_valid", 32'(bus.frame_valid), 1);
    check("after_tmo_len",   32'(bus.frame_len),   3);
    ack();

    // Reset mid-frame drops the partial frame without any error.
    q = {8'hA5, 8'h10, 8'h02, 8'h11};
    send_q();
    reset = 1'b0;
    cycles(2);
    check("rst_mid_valid", 32'(bus.frame_valid), 0);
    reset = 1'b1;
    q = {8'hA5, 8'h50, 8'h01, 8'hAA, 8'h05};
    send_q();
    check("post_rst_valid", 32'(bus.frame_valid), 1);
    check("post_rst_cmd",   32'(bus.frame_cmd),   32'h50);
    check("post_rst_len",   32'(bus.frame_len),   1);
    read_byte(0, 8'hAA, "post_rst_rd0");
    check("final_chk_cnt", 32'(n_chk), 1);
    check("final_len_cnt", 32'(n_len), 1);
    check("final_tmo_cnt", 32'(n_tmo), 1);
    check("final_ovr_cnt", 32'(n_ovr), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_frame_decoder.md
# uart_frame_decoder

Downstream consumer of the 8N1 UART receiver. Takes each received byte (`rx_byte` qualified by the one-cycle `rx_complete` pulse) and parses a framed packet of the form SOF, CMD, LEN, payload[LEN], CHK. Valid payloads are buffered in an internal byte array and presented to the command layer through a registered read port with a valid/ack handshake. Malformed, overlong, stalled or overrunning frames are flagged and discarded.

## Interface
- SOF_BYTE, 8'hA5, start-of-frame marker
- MAX_LEN, 16, maximum payload bytes (1..255); buffer depth
- TIMEOUT_CYCLES, 50000, sourceClk cycles allowed between bytes inside a frame
- sourceClk  in  1  clock
- reset  in  1  synchronous, active-low
- rx_byte  in  8  byte from UART receiver; valid only when rx_complete=1
- rx_complete  in  1  one-cycle strobe, byte available
- frame_valid  out  1  complete, checksum-good frame held in buffer
- frame_cmd  out  8  CMD byte of held frame
- frame_len  out  $clog2(MAX_LEN+1)  payload length of held frame
- frame_ack  in  1  consumer releases held frame
- rd_addr  in  $clog2(MAX_LEN)  payload byte index
- rd_data  out  8  buffer[rd_addr], registered
- err_chk  out  1  one-cycle pulse, checksum mismatch
- err_len  out  1  one-cycle pulse, LEN > MAX_LEN
- err_timeout  out  1  one-cycle pulse, inter-byte timeout
- err_overrun  out  1  one-cycle pulse, byte arrived while frame held

## Operation
- States: HUNT, CMD, LEN, PAYLOAD, CHK, HOLD. All transitions occur on an rx_complete cycle, except the timeout and frame_ack transitions.
- HUNT: when rx_byte==SOF_BYTE, go to CMD and clear sum. Any other byte is ignored silently.
- CMD: latch cmd; sum=rx_byte; go to LEN.
- LEN:
  - rx_byte>MAX_LEN: pulse err_len, go to HUNT.
  - Otherwise latch len, sum+=rx_byte, idx=0.
  - len==0: go to CHK. Else go to PAYLOAD.
- PAYLOAD: buffer[idx]=rx_byte; sum+=rx_byte; idx++. When idx reaches len-1, go to CHK.
- CHK: frame is good iff (sum+rx_byte) mod 256 == 0 (8-bit wrap).
  - Good: load frame_cmd/frame_len, set frame_valid, go to HOLD.
  - Bad: pulse err_chk, go to HUNT.
- HOLD: frame_valid=1. Buffer, frame_cmd and frame_len are frozen.
  - frame_ack=1: clear frame_valid, go to HUNT.
  - rx_complete without frame_ack: pulse err_overrun, discard byte, stay in HOLD.
- Timeout: an inter-byte counter is active in CMD, LEN, PAYLOAD and CHK.
  - Cleared on every rx_complete and on entry to those states.
  - If it reaches TIMEOUT_CYCLES-1 without a byte, pulse err_timeout and go to HUNT. The counter is idle in HUNT and HOLD.
- SOF_BYTE appearing inside CMD/LEN/PAYLOAD/CHK is data, not a resync.
- Buffer contents are undefined when frame_valid=0. rd_data is always buffer[rd_addr] of the previous cycle. rd_addr>=MAX_LEN returns undefined data.

## Timing
- Reset (reset=0 at a sourceClk edge): state HUNT. frame_valid, frame_cmd, frame_len, rd_data, all err_* become 0. sum, idx and the timeout counter are cleared. Buffer contents are not cleared.
- Reset wins over every other input in the same cycle. A partially received frame is dropped and no error is pulsed.
- frame_valid rises 1 cycle after the rx_complete carrying CHK. err_chk, err_len and err_overrun pulse 1 cycle after the offending rx_complete, for exactly 1 cycle.
- frame_ack is sampled only in HOLD; it is ignored elsewhere. frame_valid falls 1 cycle after frame_ack.
- frame_ack and rx_complete in the same HOLD cycle: the ack wins. The byte is evaluated as if in HUNT (an SOF starts a new frame). No err_overrun.
- Timeout and rx_complete in the same cycle: the byte wins. No timeout.
- rd_data latency: 1 cycle from rd_addr.
- Minimum sustained input rate: back-to-back rx_complete on consecutive cycles must be accepted without loss.

## Test plan
- Good frame: A5 10 03 11 22 33 87.
  - frame_valid=1, frame_cmd=0x10, frame_len=3.
  - rd_addr=2 gives rd_data=0x33 one cycle later.
  - frame_ack drops frame_valid next cycle.
- Bad checksum: A5 10 03 11 22 33 88.
  - err_chk pulses once, frame_valid stays 0.
  - A following good frame is accepted.
- Length and zero-length:
  - A5 01 11 (MAX_LEN=16): err_len pulse, state returns to HUNT.
  - A5 01 00 FF: valid frame with frame_len=0.
- Noise and timeout:
  - Bytes 00 FF 5A before SOF are ignored, with no error pulses.
  - A5 10 then silence for TIMEOUT_CYCLES: single err_timeout pulse; the next good frame decodes.
- Overrun: hold a good frame without ack, then send byte 0x42.
  - err_overrun pulses and the held frame is unchanged.
  - frame_ack coincident with A5 starts a new frame with no overrun.
- Reset mid-frame: reset=0 after A5 10 02 11, then send a good frame. No error pulses occur, and only the new frame is reported.
